// File: rtl/regfile_wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl_if
//   Bundles the writeback controller's bus signals: result sources, issue-stage
//   scoreboard inputs, register-file write port and scoreboard status.
//
//   Handshake: a source result transfers on a rising edge where
//   src_valid[i] & src_ready[i] are both 1. A source holding src_valid must
//   keep src_rd/src_data stable until that edge; src_ready is never a
//   function of src_valid[i] except through the round-robin grant.
//
//   Ports (per signal):
//     src_valid   [NUM_SRC]     source i presents a result
//     src_rd      [NUM_SRC*5]   destination register of source i, bits [5i+4:5i]
//     src_data    [NUM_SRC*32]  result of source i, bits [32i+31:32i]
//     src_ready   [NUM_SRC]     source i accepted this cycle
//     issue_valid               issuing an instruction that writes issue_rd
//     issue_rd    [5]           destination of issuing instruction
//     rf_we/rf_a3/rf_wd3        registered register-file write port
//     busy        [32]          outstanding-result bits (bit 0 always 0)
//     sb_err                    sticky issue-to-busy-register error
//   Modports: master = sources/issue stage/RF side, slave = controller.
// -----------------------------------------------------------------------------
interface regfile_wb_ctrl_if #(
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC*5-1:0]  src_rd;
    logic [NUM_SRC*32-1:0] src_data;
    logic [NUM_SRC-1:0]    src_ready;
    logic                  issue_valid;
    logic [4:0]            issue_rd;
    logic                  rf_we;
    logic [4:0]            rf_a3;
    logic [31:0]           rf_wd3;
    logic [31:0]           busy;
    logic                  sb_err;

    modport master (
        output src_valid, src_rd, src_data, issue_valid, issue_rd,
        input  src_ready, rf_we, rf_a3, rf_wd3, busy, sb_err
    );

    modport slave (
        input  src_valid, src_rd, src_data, issue_valid, issue_rd,
        output src_ready, rf_we, rf_a3, rf_wd3, busy, sb_err
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
//   Writeback controller and scoreboard for a 32x32 register file. Results from
//   NUM_SRC functional units are arbitrated round-robin, buffered in a
//   FIFO_DEPTH-entry FIFO and drained at one register write per cycle onto a
//   registered write port. Per-register busy bits track in-flight results.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      regfile_wb_ctrl_if.slave (sources, issue, RF write, scoreboard)
// -----------------------------------------------------------------------------
module regfile_wb_ctrl #(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_wb_ctrl_if.slave  bus
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int XW = PW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // ---------------- state ----------------
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [36:0]   mem_q [FIFO_DEPTH];
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_a3_q, rf_a3_d;
    logic [31:0]   rf_wd3_q, rf_wd3_d;
    logic [31:0]   busy_q, busy_d;
    logic          sb_err_q, sb_err_d;

    // ---------------- arbiter ----------------
    logic               found;
    logic [PW-1:0]      win_idx;
    logic [XW-1:0]      idx_ext;
    logic [NUM_SRC-1:0] grant;
    logic [4:0]         win_rd;
    logic [31:0]        win_data;
    logic               can_accept;
    logic               hs;
    logic               push;
    logic               pop;
    logic [36:0]        head;

    // Scan sources starting at rr_ptr; first valid one wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx_ext = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_ext = {1'b0, rr_ptr_q} + XW'(k);
            if (idx_ext >= XW'(NUM_SRC)) begin
                idx_ext = idx_ext - XW'(NUM_SRC);
            end
            if (!found && bus.src_valid[idx_ext[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = idx_ext[PW-1:0];
            end
        end
    end

    always_comb begin
        grant      = found ? (NUM_SRC'(1) << win_idx) : '0;
        win_rd     = bus.src_rd[int'(win_idx)*5 +: 5];
        win_data   = bus.src_data[int'(win_idx)*32 +: 32];
        can_accept = (count_q < CW'(FIFO_DEPTH)) && reset_n;
        hs         = found && can_accept;
        // Results for x0 are consumed but never buffered.
        push       = hs && (win_rd != 5'd0);
        pop        = (count_q != '0);
        head       = mem_q[rd_ptr_q];
    end

    assign bus.src_ready = grant & {NUM_SRC{can_accept}};

    // ---------------- next state ----------------
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rf_we_d  = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
        busy_d   = busy_q;
        sb_err_d = sb_err_q;

        if (hs) begin
            rr_ptr_d = (win_idx == PW'(NUM_SRC - 1)) ? '0 : win_idx + PW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rf_we_d  = 1'b1;
            rf_a3_d  = head[36:32];
            rf_wd3_d = head[31:0];
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Clear first so a same-edge issue to the same register wins.
        if (rf_we_q) begin
            busy_d[rf_a3_q] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != 5'd0) begin
            busy_d[bus.issue_rd] = 1'b1;
            if (busy_q[bus.issue_rd] && !(rf_we_q && rf_a3_q == bus.issue_rd)) begin
                sb_err_d = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            rf_a3_q  <= 5'd0;
            rf_wd3_q <= 32'd0;
            busy_q   <= 32'd0;
            sb_err_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rf_we_q  <= rf_we_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Storage needs no reset: count/pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {win_rd, win_data};
        end
    end

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_wd3 = rf_wd3_q;
    assign bus.busy   = busy_q;
    assign bus.sb_err = sb_err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
    localparam int NUM_SRC    = 3;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    regfile_wb_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

    regfile_wb_ctrl #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // exp_q holds every accepted, not-yet-written {rd,data} in acceptance order;
    // its front moves into the modelled write port once per cycle.
    logic [36:0] exp_q [$];
    int          m_rr;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    logic        m_err;

    function automatic logic [NUM_SRC-1:0] exp_ready();
        logic [NUM_SRC-1:0] r;
        bit found;
        int idx;
        r = '0;
        found = 0;
        if (reset_n && exp_q.size() < FIFO_DEPTH) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = (m_rr + k) % NUM_SRC;
                if (!found && bus.src_valid[idx]) begin
                    found = 1;
                    r[idx] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Advance one clock: snapshot inputs, let the edge happen, update the model.
    task automatic step();
        logic [NUM_SRC-1:0]    r;
        logic [NUM_SRC*5-1:0]  rds;
        logic [NUM_SRC*32-1:0] dat;
        logic                  iv;
        logic [4:0]            ird;
        logic                  rst_n;
        logic                  clr_en;
        logic [4:0]            clr_rd;
        logic [36:0]           e;
        r     = exp_ready();
        rds   = bus.src_rd;
        dat   = bus.src_data;
        iv    = bus.issue_valid;
        ird   = bus.issue_rd;
        rst_n = reset_n;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_rr = 0; m_we = 0; m_a3 = 0; m_wd = 0; m_busy = 0; m_err = 0;
        end else begin
            clr_en = m_we;
            clr_rd = m_a3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_we = 1'b1;
                m_a3 = e[36:32];
                m_wd = e[31:0];
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (r[i]) begin
                    if (rds[i*5 +: 5] != 5'd0) exp_q.push_back({rds[i*5 +: 5], dat[i*32 +: 32]});
                    m_rr = (i + 1) % NUM_SRC;
                end
            end
            if (iv && ird != 5'd0) begin
                if (m_busy[ird] && !(clr_en && clr_rd == ird)) m_err = 1'b1;
            end
            if (clr_en) m_busy[clr_rd] = 1'b0;
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
            m_busy[0] = 1'b0;
        end
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        bus.src_valid   = '0;
        bus.src_rd      = '0;
        bus.src_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
    endtask

    task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.src_valid[i]       = v;
        bus.src_rd[i*5 +: 5]   = rd;
        bus.src_data[i*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        set_src(0, 1'b1, 5'd3, 32'h1);
        set_src(2, 1'b1, 5'd4, 32'h2);
        #2;
        n_checks++;
        if (bus.src_ready !== 3'b000) $display("FAIL reset_ready: got %b expected 000", bus.src_ready);
        else n_pass++;
        step();
        step();
        clear_inputs();
        reset_n = 1'b1;
        #2;
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_a3 !== 5'd0 || bus.rf_wd3 !== 32'd0)
            $display("FAIL reset_rf: got we=%b a3=%0d wd=%h expected 0/0/0", bus.rf_we, bus.rf_a3, bus.rf_wd3);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 32'd0 || bus.sb_err !== 1'b0)
            $display("FAIL reset_sb: got busy=%h err=%b expected 0/0", bus.busy, bus.sb_err);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #2;
        n_checks++;
        if (bus.src_ready !== 3'b001) $display("FAIL single_ready: got %b expected 001", bus.src_ready);
        else n_pass++;
        step();
        clear_inputs();
        #2;
        n_checks++;
        if (bus.rf_we !== 1'b0) $display("FAIL single_we_c2: got %b expected 0", bus.rf_we);
        else n_pass++;
        step();
        #2;
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd5 || bus.rf_wd3 !== 32'hDEADBEEF)
            $display("FAIL single_write_c3: got we=%b a3=%0d wd=%h expected 1/5/deadbeef",
                     bus.rf_we, bus.rf_a3, bus.rf_wd3);
        else n_pass++;
        step();
        #2;
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_a3 !== 5'd5)
            $display("FAIL single_c4: got we=%b a3=%0d expected 0/5(held)", bus.rf_we, bus.rf_a3);
        else n_pass++;
        step();
    endtask

    task automatic test_round_robin();
        logic [NUM_SRC-1:0] exp_g;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            if (c <= 6) begin
                for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 5'(i + 1), 32'hA0000000 + 32'(c * 16 + i));
            end else begin
                clear_inputs();
            end
            #2;
            if (c <= 6) begin
                exp_g = 3'b001 << ((c - 1) % 3);
                n_checks++;
                if (bus.src_ready !== exp_g) $display("FAIL rr_grant_c%0d: got %b expected %b", c, bus.src_ready, exp_g);
                else n_pass++;
            end
            if (c >= 3) begin
                n_checks++;
                if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'(((c - 3) % 3) + 1))
                    $display("FAIL rr_a3_c%0d: got we=%b a3=%0d expected 1/%0d", c, bus.rf_we, bus.rf_a3, ((c - 3) % 3) + 1);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_x0_discard();
        do_reset();
        set_src(1, 1'b1, 5'd0, 32'h1234);
        #2;
        n_checks++;
        if (bus.src_ready !== 3'b010) $display("FAIL x0_ready: got %b expected 010", bus.src_ready);
        else n_pass++;
        step();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++;
            if (bus.rf_we !== 1'b0 || bus.busy !== 32'd0)
                $display("FAIL x0_nowrite_%0d: got we=%b busy=%h expected 0/0", c, bus.rf_we, bus.busy);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue(5'd7);                                  // c1
        step();
        clear_inputs();                               // c2
        #2;
        n_checks++;
        if (bus.busy[7] !== 1'b1) $display("FAIL sb_busy7_set: got %b expected 1", bus.busy[7]);
        else n_pass++;
        step();
        step();                                       // c3
        set_src(0, 1'b1, 5'd7, 32'h00000777);         // c4
        step();
        clear_inputs();                               // c5
        step();
        #2;                                           // c6
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd7)
            $display("FAIL sb_write7: got we=%b a3=%0d expected 1/7", bus.rf_we, bus.rf_a3);
        else n_pass++;
        issue(5'd7);                                  // re-issue on the clearing edge
        step();
        clear_inputs();                               // c7
        #2;
        n_checks++;
        if (bus.busy[7] !== 1'b1 || bus.sb_err !== 1'b0)
            $display("FAIL sb_set_wins: got busy7=%b err=%b expected 1/0", bus.busy[7], bus.sb_err);
        else n_pass++;
        set_src(0, 1'b1, 5'd7, 32'h00000778);
        step();
        clear_inputs();                               // c8
        step();
        step();                                       // c9: write rd7
        #2;                                           // c10
        n_checks++;
        if (bus.busy[7] !== 1'b0 || bus.sb_err !== 1'b0)
            $display("FAIL sb_clear7: got busy7=%b err=%b expected 0/0", bus.busy[7], bus.sb_err);
        else n_pass++;
        issue(5'd9);
        step();
        #2;                                           // c11
        n_checks++;
        if (bus.busy[9] !== 1'b1 || bus.sb_err !== 1'b0)
            $display("FAIL sb_busy9: got busy9=%b err=%b expected 1/0", bus.busy[9], bus.sb_err);
        else n_pass++;
        step();                                       // second issue of rd9
        clear_inputs();
        #2;                                           // c12
        n_checks++;
        if (bus.sb_err !== 1'b1) $display("FAIL sb_err_set: got %b expected 1", bus.sb_err);
        else n_pass++;
        step();
        #2;
        n_checks++;
        if (bus.sb_err !== 1'b1) $display("FAIL sb_err_sticky: got %b expected 1", bus.sb_err);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        issue(5'd10); step();
        issue(5'd11); step();
        issue(5'd12);
        set_src(0, 1'b1, 5'd10, 32'hCAFE0010);
        step();
        clear_inputs();
        reset_n = 1'b0;
        set_src(1, 1'b1, 5'd11, 32'hCAFE0011);
        #2;
        n_checks++;
        if (bus.src_ready !== 3'b000) $display("FAIL mid_ready_in_reset: got %b expected 000", bus.src_ready);
        else n_pass++;
        step();
        reset_n = 1'b1;
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            #2;
            n_checks++;
            if (bus.rf_we !== 1'b0 || bus.busy !== 32'd0)
                $display("FAIL mid_nowrite_%0d: got we=%b busy=%h expected 0/0", c, bus.rf_we, bus.busy);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] er;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                set_src(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            end
            bus.issue_valid = ($urandom_range(0, 3) == 0);
            bus.issue_rd    = 5'($urandom_range(0, 31));
            reset_n         = ($urandom_range(0, 60) != 0);
            #2;
            er = exp_ready();
            n_checks++;
            if (bus.src_ready !== er) $display("FAIL rnd_ready_%0d: got %b expected %b", c, bus.src_ready, er);
            else n_pass++;
            n_checks++;
            if (bus.rf_we !== m_we || bus.rf_a3 !== m_a3 || bus.rf_wd3 !== m_wd)
                $display("FAIL rnd_rf_%0d: got %b/%0d/%h expected %b/%0d/%h",
                         c, bus.rf_we, bus.rf_a3, bus.rf_wd3, m_we, m_a3, m_wd);
            else n_pass++;
            n_checks++;
            if (bus.busy !== m_busy || bus.sb_err !== m_err)
                $display("FAIL rnd_sb_%0d: got busy=%h err=%b expected %h/%b", c, bus.busy, bus.sb_err, m_busy, m_err);
            else n_pass++;
            step();
        end
        reset_n = 1'b1;
        clear_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_rr = 0; m_we = 0; m_a3 = 0; m_wd = 0; m_busy = 0; m_err = 0;
        reset_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_x0_discard();
        test_scoreboard();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
